uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-high (asserted when 1, sampled on rising clk).
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port read_rdy  input  1  consumer ready; a byte is accepted when read_vld and read_rdy are both 1 on a rising clk.
REQ-006 SHALL have port read_vld  output  1  held byte is valid.
REQ-007 SHALL have port read_data  output  8  received byte.
REQ-008 SHALL have port parity_err  output  1  odd-parity check failed for the held byte.
REQ-009 SHALL have port frame_err  output  1  stop bit sampled low for the held byte.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: a completed frame was dropped.

Function
REQ-011 Frame format SHALL be: start bit 0, 8 data bits MSB first (first data bit = read_data[7]), one odd-parity bit, one stop bit 1.
REQ-012 rx SHALL pass through a 2-flop synchronizer; all logic uses only the second flop output (rx_s) and a registered copy of it (rx_d).
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; bit counter cnt 16 bits; data bit index 0..7.
REQ-014 IDLE: on rx_d=1 and rx_s=0 (falling edge) go to START with cnt=0; a line held low never retriggers.
REQ-015 START: cnt increments each cycle; at cnt==CLKS_PER_BIT/2-1 (integer division) sample rx_s: 0 -> DATA with cnt=0, index=0; 1 -> IDLE (glitch, no output change).
REQ-016 DATA: at cnt==CLKS_PER_BIT-1 sample rx_s into shift register LSB (shift left), cnt=0, index+1; after 8th sample go to PARITY.
REQ-017 PARITY: at cnt==CLKS_PER_BIT-1 sample parity bit, cnt=0, go to STOP; parity ok when XOR of 8 data bits and parity bit equals 1.
REQ-018 STOP: at cnt==CLKS_PER_BIT-1 sample stop bit, go to IDLE the next cycle regardless of value; this is the completion cycle.
REQ-019 At completion, if read_vld=0 or read_rdy=1, SHALL load read_data, parity_err, frame_err (stop==0) and set read_vld=1 on the next edge.
REQ-020 At completion, if read_vld=1 and read_rdy=0, SHALL keep held byte/flags unchanged, drop the new frame, pulse overrun=1 for one cycle.
REQ-021 read_vld SHALL clear on acceptance unless a new byte loads in the same cycle (then stays 1 with new data).
REQ-022 read_data, parity_err, frame_err SHALL remain stable while read_vld=1 and not accepted.
REQ-023 Frames with parity or framing error SHALL still be delivered, flagged.
REQ-024 No combinational path from rx or read_rdy to any output.

Reset
REQ-025 Reset SHALL force state IDLE, cnt=0, index=0, synchronizer and rx_d to 1, read_vld=0, read_data=8'h00, parity_err=0, frame_err=0, overrun=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output; after release, reception restarts only on a new falling edge.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Verification (CLKS_PER_BIT=16, rx falling edge at cycle 0)
REQ-028 Send 0xA5, parity 1, stop 1, read_rdy=1 -> read_vld=1 from cycle 171 for one cycle, read_data=8'hA5, parity_err=0, frame_err=0.
REQ-029 Send 0x3C with parity 0 (wrong) -> read_data=8'h3C, parity_err=1, frame_err=0.
REQ-030 Send 0xFF, parity 1, stop bit 0, then line held low 100 cycles -> one byte with frame_err=1; no second frame until line returns high and falls again.
REQ-031 Low pulse of 4 cycles on idle line -> START aborts to IDLE, read_vld stays 0.
REQ-032 Two back-to-back frames 0x11, 0x22 with read_rdy=0 -> read_data=8'h11 held, overrun pulses once at second completion; raising read_rdy then drops read_vld.
REQ-033 Reset asserted at cycle 80 of a frame -> all outputs at reset values; next full 0x5A frame received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Read-side handshake of the UART receiver: valid/ready byte delivery
// together with the per-byte error flags and the overrun pulse.
interface uart_rx_if;
  logic       read_vld;
  logic       read_rdy;
  logic [7:0] read_data;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  // Receiver side: produces bytes and flags, observes consumer ready.
  modport master (
    output read_vld,
    output read_data,
    output parity_err,
    output frame_err,
    output overrun,
    input  read_rdy
  );

  // Consumer side: observes bytes and flags, drives ready.
  modport slave (
    input  read_vld,
    input  read_data,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output read_rdy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits MSB first, odd parity, one stop bit.
// The line is synchronized, the start bit is confirmed at mid-bit, and
// each following bit is sampled one bit period later. Completed frames
// are held for the consumer; a frame arriving while one is still held
// and not being accepted is dropped with an overrun pulse.
// rst_n keeps its legacy name but is synchronous and active-high.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master rd
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        done;

  logic        rx_meta, rx_s, rx_d;

  logic        vld_q;
  logic [7:0]  data_q;
  logic        perr_q;
  logic        ferr_q;
  logic        ovr_q;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  // NOTE: sequential blocks use non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the chain into a single stage.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Frame FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  // Next-state logic: bit timing and sampling of each frame field.
  // NOTE: every signal gets a default before the case so no path leaves
  // it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_d && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {shift_q[6:0], rx_s};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output holding register: load on completion, clear on acceptance,
  // drop and flag overrun when the held byte is still pending.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_q  <= 1'b0;
      data_q <= 8'h00;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done && (!vld_q || rd.read_rdy)) begin
        vld_q  <= 1'b1;
        data_q <= shift_q;
        perr_q <= ~(^shift_q ^ par_q);
        ferr_q <= ~rx_s;
      end else begin
        if (done) ovr_q <= 1'b1;
        if (vld_q && rd.read_rdy) vld_q <= 1'b0;
      end
    end
  end

  assign rd.read_vld   = vld_q;
  assign rd.read_data  = data_q;
  assign rd.parity_err = perr_q;
  assign rd.frame_err  = ferr_q;
  assign rd.overrun    = ovr_q;

endmodule
